// File: rtl/soc_capture_buffer.sv
// Multi-channel waveform capture buffer: circular pre/post-trigger history
// around a trigger event, streamed out over a valid/ready read port.
module soc_capture_buffer #(
   parameter int DATA_W   = 8,
   parameter int NUM_CH   = 2,
   parameter int DEPTH    = 256,
   parameter int PRE_TRIG = 64
) (
   input  logic                                         core_clk,
   input  logic                                         core_reset,
   input  logic [NUM_CH*DATA_W-1:0]                     sample_in,
   input  logic                                         sample_valid,
   input  logic                                         arm,
   input  logic                                         abort,
   input  logic                                         force_trig,
   input  logic [1:0]                                   trig_mode,
   input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] trig_ch,
   input  logic [DATA_W-1:0]                            trig_value,
   input  logic                                         rd_start,
   input  logic                                         rd_ready,
   output logic [NUM_CH*DATA_W-1:0]                     rd_data,
   output logic                                         rd_valid,
   output logic                                         rd_last,
   output logic                                         busy,
   output logic                                         triggered,
   output logic                                         done
);
   localparam int SW = NUM_CH*DATA_W;
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PRE_N   = (AW+1)'(PRE_TRIG);
   localparam logic [AW:0] POST_N  = (AW+1)'(DEPTH - PRE_TRIG);
   localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_PRE_FILL, S_ARMED, S_POST, S_DONE, S_READ} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, trig_addr_q, trig_addr_d, rd_addr_q, rd_addr_d;
   logic [AW:0]       cnt_q, cnt_d, rd_cnt_q, rd_cnt_d;
   logic [DATA_W-1:0] prev_q, prev_d, cur;
   logic              trig_q, trig_d, fpend_q, fpend_d;
   logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
   logic              capturing, wr_en, rd_en, hit;
   logic [SW-1:0]     mem [DEPTH];
   logic [SW-1:0]     ram_q;

   assign capturing = (state_q == S_PRE_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
   assign wr_en     = capturing && sample_valid && !abort;

   // Out-of-range channel selects fall back to channel 0.
   always_comb begin
      cur = sample_in[DATA_W-1:0];
      for (int c = 1; c < NUM_CH; c++)
         if (int'(trig_ch) == c) cur = sample_in[c*DATA_W +: DATA_W];
      hit = 1'b0;
      case (trig_mode)
         2'd0:    hit = (cur == trig_value);
         2'd1:    hit = (prev_q < trig_value) && (cur >= trig_value);
         2'd2:    hit = (prev_q > trig_value) && (cur <= trig_value);
         default: hit = (cur != prev_q);
      endcase
      hit = hit || force_trig || fpend_q;
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      trig_addr_d = trig_addr_q;
      rd_addr_d   = rd_addr_q;
      cnt_d       = cnt_q;
      rd_cnt_d    = rd_cnt_q;
      prev_d      = prev_q;
      trig_d      = trig_q;
      fpend_d     = fpend_q;
      rd_valid_d  = rd_valid_q;
      rd_last_d   = rd_last_q;
      rd_en       = 1'b0;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         prev_d   = cur;
      end
      if (abort) begin
         state_d    = S_IDLE;
         trig_d     = 1'b0;
         fpend_d    = 1'b0;
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state_d  = (PRE_N == '0) ? S_ARMED : S_PRE_FILL;
                  wr_ptr_d = '0;
                  cnt_d    = '0;
                  rd_cnt_d = '0;
                  trig_d   = 1'b0;
                  fpend_d  = 1'b0;
               end else if (rd_start && state_q == S_DONE) begin
                  state_d   = S_READ;
                  rd_addr_d = trig_addr_q - AW'(PRE_TRIG);
                  rd_cnt_d  = '0;
               end
            end
            S_PRE_FILL: begin
               if (wr_en) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q + 1'b1 == PRE_N) begin
                     state_d = S_ARMED;
                     cnt_d   = '0;
                  end
               end
            end
            S_ARMED: begin
               // The trigger sample itself is post-sample number one.
               if (sample_valid && hit) begin
                  trig_addr_d = wr_ptr_q;
                  trig_d      = 1'b1;
                  fpend_d     = 1'b0;
                  cnt_d       = (AW+1)'(1);
                  state_d     = (POST_N == (AW+1)'(1)) ? S_DONE : S_POST;
               end else if (force_trig) begin
                  fpend_d = 1'b1;
               end
            end
            S_POST: begin
               if (wr_en) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q + 1'b1 == POST_N) state_d = S_DONE;
               end
            end
            S_READ: begin
               // RAM output register doubles as the output stage; it only
               // reloads when empty or being consumed, so stalls hold data.
               if (!rd_valid_q || rd_ready) begin
                  if (rd_cnt_q != DEPTH_N) begin
                     rd_en      = 1'b1;
                     rd_valid_d = 1'b1;
                     rd_last_d  = (rd_cnt_q == DEPTH_N - 1'b1);
                     rd_addr_d  = rd_addr_q + 1'b1;
                     rd_cnt_d   = rd_cnt_q + 1'b1;
                  end else begin
                     rd_valid_d = 1'b0;
                     rd_last_d  = 1'b0;
                     state_d    = S_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge core_clk or negedge core_reset) begin
      if (!core_reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         trig_addr_q <= '0;
         rd_addr_q   <= '0;
         cnt_q       <= '0;
         rd_cnt_q    <= '0;
         prev_q      <= '0;
         trig_q      <= 1'b0;
         fpend_q     <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         trig_addr_q <= trig_addr_d;
         rd_addr_q   <= rd_addr_d;
         cnt_q       <= cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         prev_q      <= prev_d;
         trig_q      <= trig_d;
         fpend_q     <= fpend_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
      end
   end

   always_ff @(posedge core_clk) begin
      if (wr_en) mem[wr_ptr_q] <= sample_in;
      if (rd_en) ram_q <= mem[rd_addr_q];
   end

   assign rd_data   = rd_valid_q ? ram_q : '0;
   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign busy      = capturing;
   assign triggered = trig_q;
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_soc_capture_buffer.sv
// Scoreboard bench for soc_capture_buffer: directed captures push the expected
// window, a negedge monitor pops and compares every accepted readout word.
module tb_soc_capture_buffer;
   localparam int DATA_W = 8, NUM_CH = 2, DEPTH = 16, PRE_TRIG = 4;
   localparam int SW = NUM_CH*DATA_W;

   logic          core_clk = 1'b0, core_reset = 1'b0;
   logic [SW-1:0] sample_in = '0;
   logic          sample_valid = 1'b0, arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
   logic [1:0]    trig_mode = 2'd0;
   logic [0:0]    trig_ch = 1'b0;
   logic [7:0]    trig_value = 8'd0;
   logic          rd_start = 1'b0, rd_ready = 1'b1;
   logic [SW-1:0] rd_data;
   logic          rd_valid, rd_last, busy, triggered, done;

   soc_capture_buffer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
      .core_clk(core_clk), .core_reset(core_reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .arm(arm), .abort(abort), .force_trig(force_trig), .trig_mode(trig_mode), .trig_ch(trig_ch),
      .trig_value(trig_value), .rd_start(rd_start), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy), .triggered(triggered), .done(done));

   always #5 core_clk = ~core_clk;

   int            n_cmp = 0, n_bad = 0;
   logic [16:0]   sb [$];
   logic [16:0]   mon_e;
   logic          stalled = 1'b0;
   logic [SW-1:0] held = '0;

   always @(negedge core_clk) begin
      if (stalled) begin
         n_cmp++;
         if (!(rd_valid === 1'b1 && rd_data === held)) begin
            n_bad++;
            $display("FAIL stall_hold: got v=%0b d=%04h, expected v=1 d=%04h", rd_valid, rd_data, held);
         end
      end
      if (rd_valid && rd_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_word: got last=%0b d=%04h, expected no word", rd_last, rd_data);
         end else begin
            mon_e = sb.pop_front();
            if ({rd_last, rd_data} !== mon_e) begin
               n_bad++;
               $display("FAIL read_word: got last=%0b d=%04h, expected last=%0b d=%04h",
                        rd_last, rd_data, mon_e[16], mon_e[15:0]);
            end
         end
      end
      stalled = rd_valid && !rd_ready && core_reset;
      held    = rd_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge core_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c0, input logic [7:0] c1);
      sample_in    = {c1, c0};
      sample_valid = 1'b1;
      cyc();
      sample_valid = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
   endtask

   task automatic readout(input bit toggle);
      bit ok;
      ok       = 1'b0;
      rd_ready = 1'b1;
      rd_start = 1'b1;
      cyc();
      rd_start = 1'b0;
      check("rd_valid_t+1", 32'(rd_valid), 0);
      cyc();
      check("rd_valid_t+2", 32'(rd_valid), 1);
      for (int c = 0; c < 200; c++) begin
         if (sb.size() == 0 && !rd_valid) begin
            ok = 1'b1;
            break;
         end
         rd_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         cyc();
      end
      rd_ready = 1'b1;
      check("drain_timeout", 32'(ok), 1);
      check("done_after_read", 32'(done), 1);
   endtask

   function automatic logic [7:0] wave_ch1(input int t);
      case (t)
         4:       return 8'h10;
         5:       return 8'h90;
         6:       return 8'h70;
         7:       return 8'h85;
         default: return 8'h00;
      endcase
   endfunction

   // Ramp on ch0, equal-trigger at 10: window is ch0 = 6..21.
   task automatic run_ramp();
      trig_mode  = 2'd0;
      trig_ch    = 1'b0;
      trig_value = 8'd10;
      do_arm();
      check("busy_prefill", 32'(busy), 1);
      check("trig_cleared", 32'(triggered), 0);
      for (int i = 0; i < 22; i++) begin
         send(8'(i), 8'(255 - i));
         if (i == 9)  check("no_trig_before_10", 32'(triggered), 0);
         if (i == 10) check("trig_at_10", 32'({busy, triggered}), 3);
      end
      check("ramp_done", 32'({busy, done, triggered}), 3);
      for (int i = 6; i < 22; i++) sb.push_back({(i == 21), 8'(255 - i), 8'(i)});
      readout(1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cyc();
      check("reset_outputs", 32'({rd_data, rd_valid, rd_last, busy, triggered, done}), 0);
      core_reset = 1'b1;
      cyc();

      run_ramp();

      // Rising on ch1 at 0x80 fires on 0x90 only; read with 1,0,0,1 stalls.
      trig_mode  = 2'd1;
      trig_ch    = 1'b1;
      trig_value = 8'h80;
      do_arm();
      for (int i = 0; i < 4; i++) send(8'(i), 8'h00);
      send(8'd4, 8'h10);
      check("rise_not_0x10", 32'(triggered), 0);
      send(8'd5, 8'h90);
      check("rise_on_0x90", 32'(triggered), 1);
      for (int i = 6; i < 17; i++) send(8'(i), wave_ch1(i));
      check("rise_done", 32'(done), 1);
      for (int t = 1; t < 17; t++) sb.push_back({(t == 16), wave_ch1(t), 8'(t)});
      readout(1'b1);

      // Falling on the same data fires on 0x70; abort it during POST.
      trig_mode = 2'd2;
      do_arm();
      for (int i = 0; i < 4; i++) send(8'(i), 8'h00);
      send(8'd4, 8'h10);
      send(8'd5, 8'h90);
      check("fall_not_0x90", 32'(triggered), 0);
      send(8'd6, 8'h70);
      check("fall_on_0x70", 32'({busy, triggered}), 3);
      send(8'd7, 8'h85);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check("abort_post", 32'({busy, triggered, done}), 0);

      arm   = 1'b1;
      abort = 1'b1;
      cyc();
      arm   = 1'b0;
      abort = 1'b0;
      check("arm_abort_idle", 32'({busy, triggered, done}), 0);
      rd_start = 1'b1;
      cyc();
      rd_start = 1'b0;
      cyc();
      cyc();
      check("rd_start_idle", 32'({rd_valid, done}), 0);

      // 40 armed samples wrap the pointer, then a sample-less force trigger.
      trig_mode  = 2'd0;
      trig_ch    = 1'b1;
      trig_value = 8'hFF;
      do_arm();
      for (int i = 0; i < 44; i++) send(8'(i), 8'h00);
      check("no_trig_armed", 32'({busy, triggered}), 2);
      force_trig = 1'b1;
      cyc();
      force_trig = 1'b0;
      send(8'd44, 8'h00);
      check("force_trig", 32'(triggered), 1);
      for (int i = 45; i < 56; i++) send(8'(i), 8'h00);
      check("force_done", 32'(done), 1);
      for (int t = 40; t < 56; t++) sb.push_back({(t == 55), 8'h00, 8'(t)});
      readout(1'b0);

      // Reset in the middle of a re-read of the same window.
      for (int t = 40; t < 56; t++) sb.push_back({(t == 55), 8'h00, 8'(t)});
      rd_start = 1'b1;
      cyc();
      rd_start = 1'b0;
      cyc();
      cyc();
      check("reread_valid", 32'(rd_valid), 1);
      core_reset = 1'b0;
      #1;
      check("reset_mid_read", 32'({rd_data, rd_valid, rd_last, done, busy}), 0);
      sb.delete();
      cyc();
      cyc();
      core_reset = 1'b1;
      cyc();
      run_ramp();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/soc_capture_buffer.md
Name: soc_capture_buffer

Overview:
- Parametrised on-chip waveform capture buffer for the SoC core's multi-channel digital outputs (DAC bus and similar).
- Stores a circular history of samples around a configurable trigger event, then streams the window out over a valid/ready read port.
- Sits in the core_clk domain beside the rvmyth core; successor to probing a single fixed 8-bit bus with an external debug core.

Parameters:
- DATA_W, 8, bits per channel.
- NUM_CH, 2, number of channels; sample word width = NUM_CH*DATA_W, channel 0 in the LSBs.
- DEPTH, 256, buffer entries; power of two, >= 4.
- PRE_TRIG, 64, samples kept before the trigger; 0 <= PRE_TRIG < DEPTH.

Ports:
- core_clk  in  1  capture and read clock.
- core_reset  in  1  asynchronous, active-low reset.
- sample_in  in  NUM_CH*DATA_W  packed channel samples.
- sample_valid  in  1  sample_in is valid this cycle.
- arm  in  1  pulse: start a capture.
- abort  in  1  pulse: return to IDLE.
- force_trig  in  1  unconditional trigger while ARMED.
- trig_mode  in  2  0=equal, 1=rising cross, 2=falling cross, 3=any change.
- trig_ch  in  clog2(NUM_CH) (min 1)  channel compared.
- trig_value  in  DATA_W  compare threshold.
- rd_start  in  1  pulse: begin readout.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  NUM_CH*DATA_W  readout word.
- rd_valid  out  1  rd_data valid.
- rd_last  out  1  final word of window.
- busy  out  1  state is PRE_FILL, ARMED or POST.
- triggered  out  1  trigger has occurred in the current capture.
- done  out  1  state is DONE.

Behaviour:
- Reset: all outputs 0, state IDLE, write pointer 0, counters 0, prev-sample register 0.
- States: IDLE, PRE_FILL, ARMED, POST, DONE, READ.
- Priority: abort > all. abort moves to IDLE next cycle from any state, drops rd_valid, and clears triggered. Simultaneous abort+arm results in IDLE.
- arm is honoured only in IDLE or DONE. It moves to PRE_FILL (ARMED if PRE_TRIG=0) and clears the write pointer, counters and triggered. arm is ignored elsewhere.
- Writes: every sample_valid cycle in PRE_FILL/ARMED/POST writes sample_in at wr_ptr, then wr_ptr increments mod DEPTH (wraps silently). Samples are ignored in other states.
- The prev-sample register for the selected channel updates on every written sample.
- PRE_FILL: the trigger is not evaluated. After PRE_TRIG writes, the state moves to ARMED.
- ARMED: each valid sample is evaluated against the trigger.
  - Comparisons are unsigned; cur = the channel's sample, prev = the previous written sample.
  - equal: cur==value.
  - rising: prev<value && cur>=value.
  - falling: prev>value && cur<=value.
  - change: cur!=prev.
  - force_trig is ORed in; it requires no sample_valid, and in that case the next written sample is the trigger sample.
  - trig_ch >= NUM_CH selects channel 0.
- On trigger, the trigger sample is written and counted as post-sample 1. trig_addr latches its address, triggered=1, and the state moves to POST.
- If DEPTH-PRE_TRIG == 1, the state goes directly to DONE.
- POST: after DEPTH-PRE_TRIG post-samples in total, the state moves to DONE.
- Window start = (trig_addr - PRE_TRIG) mod DEPTH. The window always holds exactly DEPTH entries in chronological order.
- DONE: rd_start moves to READ with rd_addr = window start. Synchronous RAM read; rd_valid rises 2 cycles after the rd_start cycle.
- READ handshake:
  - Word advances on rd_valid && rd_ready. rd_data and rd_valid must hold stable while rd_ready=0.
  - Full throughput: one word per cycle when rd_ready stays high.
  - rd_last=1 with word DEPTH-1 (0-based). After it is accepted, rd_valid=0 next cycle and the state returns to DONE.
  - The window may be re-read; arm in DONE starts a new capture.
- rd_start outside DONE is ignored. sample_valid during READ/DONE is ignored, so the buffer content is frozen.
- Reset asserted mid-operation returns immediately to reset values. RAM content is undefined and never exposed without a new capture.

Test Plan:
- Params DATA_W=8,NUM_CH=2,DEPTH=16,PRE_TRIG=4. Ch0 ramp 0,1,2..., mode=equal, value=10, arm, full rd_ready -> busy during capture, trigger at ch0=10, done=1. Readout ch0 = 6..21, rd_last on 21, rd_valid 2 cycles after rd_start.
- Rising mode, value=0x80, ch1 sequence 0x10,0x90,0x70,0x85 after PRE_FILL -> trigger on 0x90 only. Falling mode, value=0x80, same data -> trigger on 0x70.
- rd_ready toggled 1,0,0,1 pattern -> rd_data stable while stalled, no word skipped or duplicated, exactly 16 words, rd_last once.
- Arm, 40 samples in ARMED without trigger (pointer wraps), then force_trig -> window = 4 samples before the forced point plus 12 after, in order.
- abort during POST and arm+abort same cycle -> IDLE next cycle, triggered=0, done=0. rd_start in IDLE -> no rd_valid.
- core_reset low mid-READ -> rd_valid, rd_last, done, busy all 0 immediately. After release, arm restarts cleanly.
